// File: rtl/weight_scratchpad_loader_if.sv
// Weight scratchpad loader bus: word stream in, column vector out.
// The slave side is the loader. The master side is the producer/consumer.
interface weight_scratchpad_loader_if #(
  parameter int WEIGHT_WIDTH = 5,
  parameter int WEIGHT_ROWS  = 96,
  parameter int WEIGHT_COLS  = 3
);
  localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  logic                                     clear_in;
  logic                                     w_valid_in;
  logic [WEIGHT_WIDTH-1:0]                  w_data_in;
  logic                                     w_ready_out;
  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] scratchpad_out;
  logic                                     vec_valid_out;
  logic                                     vec_ack_in;
  logic [COL_W-1:0]                         col_idx_out;
  logic                                     done_out;

  modport slave (
    input  clear_in,
    input  w_valid_in,
    input  w_data_in,
    output w_ready_out,
    output scratchpad_out,
    output vec_valid_out,
    input  vec_ack_in,
    output col_idx_out,
    output done_out
  );

  modport master (
    output clear_in,
    output w_valid_in,
    output w_data_in,
    input  w_ready_out,
    input  scratchpad_out,
    input  vec_valid_out,
    output vec_ack_in,
    input  col_idx_out,
    input  done_out
  );
endinterface

// File: rtl/weight_scratchpad_loader.sv
// Weight scratchpad loader.
// It collects WEIGHT_ROWS words from a valid/ready stream into one column.
// It then presents the column under a valid/ack handshake and steps through WEIGHT_COLS columns.
// Optional macro LOADER_PINGPONG_EN adds a second column bank, so the next column
// can fill while the current column waits for its ack.
module weight_scratchpad_loader #(
  parameter int WEIGHT_WIDTH = 5,
  parameter int WEIGHT_ROWS  = 96,
  parameter int WEIGHT_COLS  = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  weight_scratchpad_loader_if.slave bus
);

  localparam int ROW_W = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;
  localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WEIGHT_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WEIGHT_COLS - 1);

  typedef logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] column_t;
  typedef enum logic {FILL = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_idx;
  logic             vec_valid;
  logic             done;
  logic             xfer;
  logic             last_xfer;

  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
    return (c == COL_LAST) ? '0 : c + 1'b1;
  endfunction

  assign bus.vec_valid_out = vec_valid;
  assign bus.col_idx_out   = col_idx;
  assign bus.done_out      = done;
  assign last_xfer         = xfer && (row_cnt == ROW_LAST);

`ifdef LOADER_PINGPONG_EN

  // The presented bank is bank[pres_sel]. The fill bank is the other one.
  // fill_full marks a fill bank that has a complete column waiting to be presented.
  column_t bank [2];
  logic    pres_sel;
  logic    fill_sel;
  logic    fill_full;

  assign fill_sel           = ~pres_sel;
  assign xfer               = bus.w_valid_in && !fill_full;
  assign bus.w_ready_out    = rst_n && !fill_full;
  assign bus.scratchpad_out = bank[pres_sel];

  // Fill/present control with two banks. A completed fill bank is handed over on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      row_cnt   <= '0;
      col_idx   <= '0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
      pres_sel  <= 1'b0;
      fill_full <= 1'b0;
      bank[0]   <= '0;
      bank[1]   <= '0;
    end else begin
      done <= 1'b0;
      if (bus.clear_in) begin
        state     <= FILL;
        row_cnt   <= '0;
        col_idx   <= '0;
        vec_valid <= 1'b0;
        fill_full <= 1'b0;
      end else begin
        if (xfer) begin
          bank[fill_sel][row_cnt] <= bus.w_data_in;
          row_cnt                 <= last_xfer ? '0 : row_cnt + 1'b1;
        end
        if (state == PRESENT && bus.vec_ack_in) begin
          col_idx <= next_col(col_idx);
          done    <= (col_idx == COL_LAST);
          if (fill_full || last_xfer) begin
            // The next column is already complete, so the output stays valid without a gap.
            pres_sel  <= ~pres_sel;
            fill_full <= 1'b0;
          end else begin
            state     <= FILL;
            vec_valid <= 1'b0;
          end
        end else if (last_xfer) begin
          if (state == FILL) begin
            pres_sel  <= ~pres_sel;
            state     <= PRESENT;
            vec_valid <= 1'b1;
          end else begin
            fill_full <= 1'b1;
          end
        end
      end
    end
  end

`else

  column_t col_buf;

  assign xfer               = bus.w_valid_in && (state == FILL);
  assign bus.w_ready_out    = rst_n && (state == FILL);
  assign bus.scratchpad_out = col_buf;

  // Single-bank FSM: fill one word per transfer, then hold the column until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      row_cnt   <= '0;
      col_idx   <= '0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
      col_buf   <= '0;
    end else begin
      done <= 1'b0;
      if (bus.clear_in) begin
        // Buffer contents survive a clear. Only the control state restarts.
        state     <= FILL;
        row_cnt   <= '0;
        col_idx   <= '0;
        vec_valid <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (xfer) begin
              col_buf[row_cnt] <= bus.w_data_in;
              if (last_xfer) begin
                row_cnt   <= '0;
                state     <= PRESENT;
                vec_valid <= 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          PRESENT: begin
            if (bus.vec_ack_in) begin
              state     <= FILL;
              vec_valid <= 1'b0;
              col_idx   <= next_col(col_idx);
              done      <= (col_idx == COL_LAST);
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

`endif

endmodule
